model_access_arbiter: RTL and testbench

MODEL_ACCESS_ARBITER -- requirements
Module: model_access_arbiter

---
 rtl/model_access_arbiter.sv | 121 ++++++++++++
 tb/tb_model_access_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/model_access_arbiter.sv
// Two-requester round-robin arbiter for a pair of bus models sharing one data bus.
// Each transaction runs IDLE -> SETUP -> ACCESS -> DONE, and every output is registered.
module model_access_arbiter #(
   parameter int unsigned WordSize = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [1:0]            REQ,
   input  logic [1:0]            REQ_WR,
   input  logic [1:0]            REQ_BANK,
   input  logic [2*WordSize-1:0] REQ_WDATA,
   output logic [1:0]            GNT,
   output logic [1:0]            DONE,
   output logic [WordSize-1:0]   RDATA,
   output logic                  BUSY,
   output logic                  CS,
   output logic                  WE,
   output logic [WordSize-1:0]   BUS_OUT,
   output logic                  BUS_OE,
   input  logic [WordSize-1:0]   BUS_IN
);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

   state_e              state_q, state_d;
   logic                ptr_q, ptr_d;
   logic                sel_q, sel_d;
   logic                wr_q, wr_d;
   logic                bank_q, bank_d;
   logic [WordSize-1:0] wdata_q, wdata_d;
   logic [WordSize-1:0] rdata_q, rdata_d;
   logic [1:0]          gnt_q, gnt_d;
   logic [1:0]          done_q, done_d;
   logic                busy_q, busy_d;
   logic                cs_q, cs_d;
   logic                we_q, we_d;
   logic                oe_q, oe_d;
   logic                pick;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      wr_d    = wr_q;
      bank_d  = bank_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      // When both requesters are active the pointer decides; otherwise the lone requester wins.
      pick    = (REQ == 2'b11) ? ptr_q : REQ[1];

      unique case (state_q)
         StIdle: begin
            if (REQ != 2'b00) begin
               state_d = StSetup;
               sel_d   = pick;
               ptr_d   = ~pick;
               wr_d    = REQ_WR[pick];
               bank_d  = REQ_BANK[pick];
               wdata_d = pick ? REQ_WDATA[2*WordSize-1:WordSize] : REQ_WDATA[WordSize-1:0];
            end
         end
         StSetup:  state_d = StAccess;
         StAccess: begin
            state_d = StDone;
            if (!wr_q) rdata_d = BUS_IN;
         end
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase

      // Output registers are loaded with the values that belong to the state being entered.
      gnt_d  = (state_d == StSetup) ? {sel_d, ~sel_d} : 2'b00;
      done_d = (state_d == StDone) ? {sel_q, ~sel_q} : 2'b00;
      busy_d = (state_d != StIdle);
      cs_d   = (state_d == StIdle) ? 1'b1 : ~bank_d;
      we_d   = (state_d == StAccess) && wr_q;
      oe_d   = we_d;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         ptr_q   <= 1'b0;
         sel_q   <= 1'b0;
         wr_q    <= 1'b0;
         bank_q  <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         gnt_q   <= 2'b00;
         done_q  <= 2'b00;
         busy_q  <= 1'b0;
         cs_q    <= 1'b1;
         we_q    <= 1'b0;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         wr_q    <= wr_d;
         bank_q  <= bank_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         cs_q    <= cs_d;
         we_q    <= we_d;
         oe_q    <= oe_d;
      end
   end

   assign GNT     = gnt_q;
   assign DONE    = done_q;
   assign RDATA   = rdata_q;
   assign BUSY    = busy_q;
   assign CS      = cs_q;
   assign WE      = we_q;
   assign BUS_OE  = oe_q;
   assign BUS_OUT = wdata_q;

endmodule

// File: tb/tb_model_access_arbiter.sv
// Directed bench for model_access_arbiter: hand-computed expectations plus per-cycle invariants.
module tb_model_access_arbiter;

   localparam int unsigned WordSize = 8;

   logic                  CLK = 1'b0;
   logic                  RST;
   logic [1:0]            REQ, REQ_WR, REQ_BANK;
   logic [2*WordSize-1:0] REQ_WDATA;
   logic [1:0]            GNT, DONE;
   logic [WordSize-1:0]   RDATA, BUS_OUT, BUS_IN;
   logic                  BUSY, CS, WE, BUS_OE;

   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;

   always #5 CLK = ~CLK;

   model_access_arbiter #(.WordSize(WordSize)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .REQ       (REQ),
      .REQ_WR    (REQ_WR),
      .REQ_BANK  (REQ_BANK),
      .REQ_WDATA (REQ_WDATA),
      .GNT       (GNT),
      .DONE      (DONE),
      .RDATA     (RDATA),
      .BUSY      (BUSY),
      .CS        (CS),
      .WE        (WE),
      .BUS_OUT   (BUS_OUT),
      .BUS_OE    (BUS_OE),
      .BUS_IN    (BUS_IN)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one edge and settle so the following checks see the new cycle.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   always @(negedge CLK) begin
      if (mon_en) begin
         check("inv_we_oe", {31'd0, WE & ~BUS_OE}, 32'd0);
         check("inv_gnt_done", {31'd0, (|GNT) & (|DONE)}, 32'd0);
         check("inv_gnt_1hot", {31'd0, $onehot0(GNT)}, 32'd1);
         check("inv_done_1hot", {31'd0, $onehot0(DONE)}, 32'd1);
      end
   end

   initial begin
      RST = 1'b1; REQ = 2'b00; REQ_WR = 2'b00; REQ_BANK = 2'b00;
      REQ_WDATA = '0; BUS_IN = '0;
      tick(); tick();
      check("rst_gnt", {30'd0, GNT}, 32'd0);
      check("rst_done", {30'd0, DONE}, 32'd0);
      check("rst_busy", {31'd0, BUSY}, 32'd0);
      check("rst_cs", {31'd0, CS}, 32'd1);
      check("rst_we", {31'd0, WE}, 32'd0);
      check("rst_oe", {31'd0, BUS_OE}, 32'd0);
      check("rst_bus_out", {24'd0, BUS_OUT}, 32'd0);
      check("rst_rdata", {24'd0, RDATA}, 32'd0);
      mon_en = 1'b1;
      RST = 1'b0;

      // Write A5 to bank 0 by requester 0.
      REQ = 2'b01; REQ_WR = 2'b01; REQ_BANK = 2'b00; REQ_WDATA = 16'h00A5;
      tick();
      check("w0_gnt", {30'd0, GNT}, 32'h1);
      check("w0_busy", {31'd0, BUSY}, 32'd1);
      check("w0_setup_we", {31'd0, WE}, 32'd0);
      REQ = 2'b00;
      tick();
      check("w0_cs", {31'd0, CS}, 32'd1);
      check("w0_we", {31'd0, WE}, 32'd1);
      check("w0_oe", {31'd0, BUS_OE}, 32'd1);
      check("w0_bus_out", {24'd0, BUS_OUT}, 32'hA5);
      check("w0_gnt_off", {30'd0, GNT}, 32'd0);
      tick();
      check("w0_done", {30'd0, DONE}, 32'h1);
      check("w0_done_we", {31'd0, WE}, 32'd0);
      check("w0_rdata_kept", {24'd0, RDATA}, 32'd0);
      tick();
      check("w0_idle_busy", {31'd0, BUSY}, 32'd0);
      check("w0_idle_done", {30'd0, DONE}, 32'd0);

      // Read bank 1 by requester 1; BUS_IN valid only during ACCESS.
      REQ = 2'b10; REQ_WR = 2'b00; REQ_BANK = 2'b10;
      tick();
      check("r1_gnt", {30'd0, GNT}, 32'h2);
      check("r1_setup_cs", {31'd0, CS}, 32'd0);
      check("r1_setup_oe", {31'd0, BUS_OE}, 32'd0);
      REQ = 2'b00;
      tick();
      check("r1_acc_cs", {31'd0, CS}, 32'd0);
      check("r1_acc_we", {31'd0, WE}, 32'd0);
      check("r1_acc_oe", {31'd0, BUS_OE}, 32'd0);
      BUS_IN = 8'h3C;
      tick();
      BUS_IN = 8'h00;
      check("r1_done", {30'd0, DONE}, 32'h2);
      check("r1_rdata", {24'd0, RDATA}, 32'h3C);
      check("r1_done_cs", {31'd0, CS}, 32'd0);
      tick();
      check("r1_rdata_hold", {24'd0, RDATA}, 32'h3C);
      check("r1_idle_cs", {31'd0, CS}, 32'd1);

      // Both requesting from reset: strict alternation at 4-cycle spacing.
      RST = 1'b1; REQ = 2'b11; REQ_WR = 2'b00; REQ_BANK = 2'b00;
      tick();
      RST = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("rr_gnt%0d", i), {30'd0, GNT}, (i % 2 == 0) ? 32'h1 : 32'h2);
         tick();
         check($sformatf("rr_gap_a%0d", i), {30'd0, GNT}, 32'd0);
         tick();
         check($sformatf("rr_done%0d", i), {30'd0, DONE}, (i % 2 == 0) ? 32'h1 : 32'h2);
         tick();
         check($sformatf("rr_gap_b%0d", i), {30'd0, GNT}, 32'd0);
      end
      REQ = 2'b00;
      tick();
      check("rr_quiet", {31'd0, BUSY}, 32'd0);

      // Reset during ACCESS of a write aborts it and re-homes the pointer.
      REQ = 2'b01; REQ_WR = 2'b01; REQ_BANK = 2'b00; REQ_WDATA = 16'h005A;
      tick();
      check("ab_gnt", {30'd0, GNT}, 32'h1);
      REQ = 2'b00;
      tick();
      check("ab_we", {31'd0, WE}, 32'd1);
      RST = 1'b1;
      tick();
      check("ab_we_off", {31'd0, WE}, 32'd0);
      check("ab_busy_off", {31'd0, BUSY}, 32'd0);
      check("ab_no_done", {30'd0, DONE}, 32'd0);
      RST = 1'b0; REQ = 2'b11; REQ_WR = 2'b00;
      tick();
      check("ab_next_gnt", {30'd0, GNT}, 32'h1);
      REQ = 2'b00;
      tick();
      tick();
      check("ab_next_done", {30'd0, DONE}, 32'h1);
      tick();

      // Write data changed in SETUP must not leak into the transaction.
      REQ = 2'b10; REQ_WR = 2'b10; REQ_BANK = 2'b00; REQ_WDATA = 16'h7700;
      tick();
      check("lt_gnt", {30'd0, GNT}, 32'h2);
      REQ_WDATA = 16'hFFFF; REQ = 2'b00; REQ_WR = 2'b00; REQ_BANK = 2'b11;
      tick();
      check("lt_bus_out", {24'd0, BUS_OUT}, 32'h77);
      check("lt_we", {31'd0, WE}, 32'd1);
      check("lt_cs", {31'd0, CS}, 32'd1);
      tick();
      check("lt_done", {30'd0, DONE}, 32'h2);
      check("lt_bus_out_hold", {24'd0, BUS_OUT}, 32'h77);
      tick();

      // Request withdrawn before any edge samples it.
      REQ = 2'b01;
      #3;
      REQ = 2'b00;
      tick();
      check("drop_gnt", {30'd0, GNT}, 32'd0);
      check("drop_busy", {31'd0, BUSY}, 32'd0);
      tick();

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
